// File: rtl/krnl_sobel_div_pkg.sv
// Shared definitions for the sequential unsigned divider used by the Sobel kernel.
// Holds the default operand widths, the iteration-counter width helper and the
// divider FSM state encoding.
package krnl_sobel_div_pkg;

  localparam int DIVIDEND_W_DEF = 32;
  localparam int DIVISOR_W_DEF  = 16;

  // Counter must be able to hold the value DIVIDEND_W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/krnl_sobel_udiv_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep or restore.
// Ports:
//   rem_i     - current partial remainder (DIVISOR_W+1 bits)
//   bit_i     - next dividend bit, MSB first
//   divisor_i - divisor
//   rem_o     - updated partial remainder
//   q_bit_o   - quotient bit produced by this iteration
module krnl_sobel_udiv_step #(
  parameter int DIVISOR_W = 16
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W+1:0] shifted_s;
  logic [DIVISOR_W+1:0] trial_s;

  // Full-width shifted remainder keeps the top bit so the borrow is exact.
  assign shifted_s = {rem_i, bit_i};
  assign trial_s   = shifted_s - {2'b00, divisor_i};
  // Borrow out of the trial subtract means the divisor did not fit.
  assign q_bit_o   = ~trial_s[DIVISOR_W+1];
  assign rem_o     = q_bit_o ? trial_s[DIVISOR_W:0] : shifted_s[DIVISOR_W:0];

endmodule

// File: rtl/krnl_sobel_udiv_32ns_16ns_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Fixed latency of DIVIDEND_W cycles from acceptance to result.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_ready  - operand handshake (ready only in IDLE)
//   dividend, divisor  - unsigned operands
//   out_valid/out_ready- result handshake (valid only in DONE)
//   quotient, remainder- result; divisor==0 gives all-ones / dividend low bits
//   div_by_zero        - result came from a zero divisor
module krnl_sobel_udiv_32ns_16ns_seq
  import krnl_sobel_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  // Dividend shifts out at the top while quotient bits shift in at the bottom.
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic                  dbz_q;

  logic [DIVISOR_W:0]    rem_step_s;
  logic                  q_bit_s;
  logic                  last_s;

  krnl_sobel_udiv_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_step_s),
    .q_bit_o   (q_bit_s)
  );

  assign last_s = (cnt_q == LAST_ITER);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_BUSY;
        else          state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_BUSY;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_BUSY: in_ready  = 1'b0;
      ST_DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: capture on acceptance, iterate in BUSY, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dvd_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cnt_q <= '0;
            dvd_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            dbz_q <= (divisor == '0);
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A zero divisor forces every quotient bit to one.
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], q_bit_s | dbz_q};
          rem_q <= rem_step_s;
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  assign quotient    = dvd_q;
  assign remainder   = rem_q[DIVISOR_W-1:0];
  assign div_by_zero = dbz_q;

endmodule
